ws2812_input_decoder: RTL and testbench

Receives a WS2812-style single-wire NRZ pulse stream and converts it into bytes, MSB first. It measures each high pulse in clock cycles to decide between 0 and 1 bits, and detects the low "reset/latch" gap that ends a frame. It is the receive-side counterpart of `ws2812_output_shifter`. Uses: loopback checking of the fader chain on the J1 header, and acting as a downstream pixel in test setups.

---
 rtl/ws2812_input_decoder.sv | 181 ++++++++++++++++++
 tb/tb_ws2812_input_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_input_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_input_decoder
//  Purpose  : Decodes a WS2812-style single-wire NRZ pulse stream into bytes,
//             MSB first. Each high pulse is timed in clk cycles to decide
//             between 0 and 1. A long low gap closes the frame (latch).
//             Malformed pulses or a partial byte at latch raise error.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-high reset
//             din        - serial line, asynchronous to clk
//             data       - last completed byte (MSB = first bit received)
//             data_valid - 1-cycle strobe when data is updated
//             latch      - 1-cycle strobe on frame-end gap
//             error      - 1-cycle strobe on bad pulse / partial byte at latch
//             busy       - high from first rising edge of a frame to its end
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_input_decoder #(
    parameter int THRESH_CYCLES   = 6,
    parameter int MIN_HIGH_CYCLES = 2,
    parameter int MAX_HIGH_CYCLES = 12,
    parameter int LATCH_CYCLES    = 600,
    parameter int CNT_WIDTH       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       latch,
    output logic       error,
    output logic       busy
);

    localparam logic [CNT_WIDTH-1:0] c_THRESH = CNT_WIDTH'(THRESH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_MIN    = CNT_WIDTH'(MIN_HIGH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_MAX    = CNT_WIDTH'(MAX_HIGH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_LATCH  = CNT_WIDTH'(LATCH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HIGH   = 2'd1,
        S_LOW    = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;     // sync_q[1] is the synchronized line din_s
    logic                 din_q;      // previous din_s, for edge detection
    logic [1:0]           warm_q;     // counts cycles since reset release
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    // Only seven bits are stored: the eighth bit goes straight into data.
    logic [6:0]           sh_q;
    logic [2:0]           bitcnt_q;
    logic [7:0]           data_q;
    logic                 data_valid_q;
    logic                 latch_q;
    logic                 error_q;
    logic                 busy_q;

    logic w_din_s;
    logic w_edges_ok;
    logic w_rise;
    logic w_fall;
    logic w_bit;

    assign w_din_s = sync_q[1];

    // The synchronizer resets to 0, so a line that is already high at reset
    // release would look like a rising edge. Edges are ignored until the
    // whole edge-detect chain holds real line samples, so such a pulse is
    // treated as already in progress and its falling edge lands in IDLE.
    assign w_edges_ok = (warm_q == 2'd3);
    assign w_rise     = w_edges_ok &  w_din_s & ~din_q;
    assign w_fall     = w_edges_ok & ~w_din_s &  din_q;
    assign w_bit      = (cnt_q >= c_THRESH);

    // Level-duration counter: restarts at 1 on any edge, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (w_rise || w_fall) begin
            cnt_d = c_ONE;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b00;
            din_q        <= 1'b0;
            warm_q       <= 2'd0;
            cnt_q        <= '0;
            sh_q         <= 7'd0;
            bitcnt_q     <= 3'd0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            latch_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], din};
            din_q        <= w_din_s;
            cnt_q        <= cnt_d;
            data_valid_q <= 1'b0;
            latch_q      <= 1'b0;
            error_q      <= 1'b0;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        state_q <= S_HIGH;
                        busy_q  <= 1'b1;
                    end
                end

                S_HIGH: begin
                    if (w_fall) begin
                        // cnt_q holds the completed high time here.
                        if (cnt_q < c_MIN) begin
                            error_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            bitcnt_q <= 3'd0;
                            state_q  <= S_RESYNC;
                        end else begin
                            sh_q     <= {sh_q[5:0], w_bit};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                data_q       <= {sh_q, w_bit};
                                data_valid_q <= 1'b1;
                            end
                            state_q <= S_LOW;
                        end
                    end else if (cnt_d > c_MAX) begin
                        error_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        bitcnt_q <= 3'd0;
                        state_q  <= S_RESYNC;
                    end
                end

                S_LOW: begin
                    if (w_rise) begin
                        state_q <= S_HIGH;
                    end else if (cnt_d == c_LATCH) begin
                        latch_q  <= 1'b1;
                        error_q  <= (bitcnt_q != 3'd0);
                        busy_q   <= 1'b0;
                        bitcnt_q <= 3'd0;
                        state_q  <= S_IDLE;
                    end
                end

                S_RESYNC: begin
                    // Silent recovery: wait for a full latch-length low gap.
                    if (!w_din_s && (cnt_d == c_LATCH)) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign latch      = latch_q;
    assign error      = error_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_input_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws2812_input_decoder
//  Purpose  : Self-checking bench for ws2812_input_decoder. Expected output
//             events (bytes, latch, error) are queued as stimulus is driven
//             and compared in order as the decoder produces strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_input_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       data_valid;
    logic       latch;
    logic       error;
    logic       busy;

    ws2812_input_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .data       (data),
        .data_valid (data_valid),
        .latch      (latch),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];      // {error, latch, data_valid, data}
    int          dv_cyc[$];
    int          latch_cyc = -1;
    int          err_cyc   = -1;
    int          fall_cyc  = 0;
    logic [10:0] mon_obs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int hi1 = 9, input int hi0 = 4);
        int hi;
        hi  = b ? hi1 : hi0;
        din = 1'b1;
        repeat (hi) tick();
        din      = 1'b0;
        fall_cyc = cyc;
        repeat (15 - hi) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_out = 1'b1,
                             input int hi1 = 9, input int hi0 = 4);
        if (expect_out) exp_q.push_back({3'b001, b});
        for (int i = 7; i >= 0; i--) send_bit(b[i], hi1, hi0);
    endtask

    task automatic gap(input int n, input bit exp_latch, input bit exp_err);
        if (exp_latch) exp_q.push_back({exp_err, 2'b10, 8'h00});
        repeat (n) tick();
    endtask

    // Event monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && (data_valid || latch || error)) begin
            mon_obs = {error, latch, data_valid, (data_valid ? data : 8'h00)};
            if (data_valid) dv_cyc.push_back(cyc);
            if (latch)      latch_cyc = cyc;
            if (error)      err_cyc   = cyc;
            if (exp_q.size() == 0) check_eq("unexpected_event", 32'(mon_obs), 32'h0);
            else                   check_eq("event", 32'(mon_obs), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int fall8;
        int rise_c;
        logic [7:0] a5;

        rst = 1'b1;
        din = 1'b0;
        repeat (3) tick();
        check_eq("reset_data", 32'(data), 32'h00);
        check_eq("reset_strobes", 32'({data_valid, latch, error, busy}), 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        // Single byte 0xA5, first bit driven by hand to time busy.
        a5 = 8'hA5;
        exp_q.push_back({3'b001, a5});
        dv_cyc.delete();
        din = 1'b1;
        tick();
        tick();
        check_eq("busy_before", 32'(busy), 32'h0);
        tick();
        check_eq("busy_rise", 32'(busy), 32'h1);
        repeat (6) tick();
        din = 1'b0;
        repeat (6) tick();
        for (int i = 6; i >= 0; i--) send_bit(a5[i]);
        fall8 = fall_cyc;
        check_eq("busy_frame", 32'(busy), 32'h1);
        gap(620, 1'b1, 1'b0);
        check_eq("dv_count_a5", 32'(dv_cyc.size()), 32'd1);
        check_eq("dv_latency", 32'((dv_cyc.size() > 0) ? dv_cyc[0] - fall8 : -1), 32'd3);
        check_eq("latch_latency", 32'(latch_cyc - fall8), 32'd602);
        check_eq("busy_after_latch", 32'(busy), 32'h0);
        check_eq("data_hold", 32'(data), 32'hA5);

        // Three pixels back-to-back.
        dv_cyc.delete();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        gap(700, 1'b1, 1'b0);
        check_eq("dv_count_3px", 32'(dv_cyc.size()), 32'd3);
        check_eq("dv_spacing_1", 32'((dv_cyc.size() == 3) ? dv_cyc[1] - dv_cyc[0] : -1), 32'd120);
        check_eq("dv_spacing_2", 32'((dv_cyc.size() == 3) ? dv_cyc[2] - dv_cyc[1] : -1), 32'd120);

        // Threshold boundaries: 6 cycles high is a 1, 5 cycles is a 0.
        send_byte(8'h96, 1'b1, 6, 5);
        gap(620, 1'b1, 1'b0);

        // One-cycle glitch, ignored bits during RESYNC, then a clean 0xFF.
        exp_q.push_back({3'b100, 8'h00});
        din = 1'b1;
        tick();
        din = 1'b0;
        repeat (14) tick();
        check_eq("busy_resync", 32'(busy), 32'h0);
        send_byte(8'hC3, 1'b0);
        gap(620, 1'b0, 1'b0);
        send_byte(8'hFF);
        gap(620, 1'b1, 1'b0);

        // Stuck high for 20 cycles: error once cnt reaches 13, no latch after.
        exp_q.push_back({3'b100, 8'h00});
        rise_c = cyc;
        din    = 1'b1;
        repeat (20) tick();
        din = 1'b0;
        check_eq("stuck_err_time", 32'(err_cyc - rise_c), 32'd15);
        check_eq("busy_stuck", 32'(busy), 32'h0);
        gap(700, 1'b0, 1'b0);

        // Partial byte: latch and error together, then 0x3C decodes cleanly.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        gap(620, 1'b1, 1'b1);
        send_byte(8'h3C);
        gap(620, 1'b1, 1'b0);
        check_eq("data_3c", 32'(data), 32'h3C);

        // Reset mid-byte of 0xF0 with the line high, then 0x0F.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        din = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_data", 32'(data), 32'h00);
        check_eq("midrst_strobes", 32'({data_valid, latch, error, busy}), 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        din = 1'b0;
        repeat (20) tick();
        check_eq("busy_after_rst", 32'(busy), 32'h0);
        dv_cyc.delete();
        send_byte(8'h0F);
        gap(620, 1'b1, 1'b0);
        check_eq("dv_count_0f", 32'(dv_cyc.size()), 32'd1);
        check_eq("data_0f", 32'(data), 32'h0F);

        check_eq("events_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
